// File: rtl/dmem_io_pkg.sv
// Shared definitions for the data-memory / memory-mapped I/O stage:
// I/O register addresses, the digit index type and the seven-segment glyph table.
package dmem_io_pkg;

  localparam logic [7:0] ADDR_SW   = 8'h80;
  localparam logic [7:0] ADDR_LED  = 8'h84;
  localparam logic [7:0] ADDR_DISP = 8'h88;
  localparam logic [7:0] ADDR_STAT = 8'h8C;

  typedef logic [2:0] digit_t;

  // Active-low segments packed as {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/dmem_io_hex7seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex7seg
  import dmem_io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/dmem_io.sv
// Data RAM plus memory-mapped switches, LEDs and an 8-digit scanned hex display.
// Optional build macro DMEM_IO_BLANK_EN blanks leading zero digits of the display.
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int SCAN_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]          ram [RAM_WORDS];
  logic [AW-1:0]        ram_idx;
  logic [7:0]           io_addr;
  logic                 io_sel;
  logic [15:0]          led_reg;
  logic [31:0]          disp_reg;
  logic [SCAN_BITS-1:0] cnt_reg;
  logic [15:0]          sw_meta_reg;
  logic [15:0]          sw_sync_reg;
  logic [7:0]           an_reg;
  logic [6:0]           seg_reg;
  digit_t               digit;
  logic [3:0]           nibble;
  logic [6:0]           seg_next;
  logic [7:0]           an_next;
  logic                 digit_on;
  logic                 unused_adr;

  assign ram_idx    = dataadr[AW+1:2];
  assign io_addr    = {dataadr[7:2], 2'b00};
  assign io_sel     = dataadr[7];
  assign unused_adr = &{1'b0, dataadr[31:8], dataadr[1:0]};

  assign digit  = cnt_reg[SCAN_BITS-1 -: 3];
  assign nibble = disp_reg[{digit, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg_next)
  );

`ifdef DMEM_IO_BLANK_EN
  // A digit stays lit if it or any more-significant nibble is nonzero.
  logic [7:0] nz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_nz
    assign nz[gi] = |disp_reg[4*gi +: 4];
  end
  assign digit_on = (digit == 3'd0) || (|(nz >> digit));
`else
  assign digit_on = 1'b1;
`endif

  assign an_next = digit_on ? ~(8'b0000_0001 << digit) : 8'hFF;

  // Stores are dropped while reset is held.
  always_ff @(posedge clk) begin
    if (memwrite && !io_sel && !reset) begin
      ram[ram_idx] <= writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg     <= '0;
      disp_reg    <= '0;
      cnt_reg     <= '0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
      an_reg      <= 8'hFE;
      seg_reg     <= 7'b1000000;
    end else begin
      cnt_reg     <= cnt_reg + SCAN_BITS'(1);
      sw_meta_reg <= switch;
      sw_sync_reg <= sw_meta_reg;
      an_reg      <= an_next;
      seg_reg     <= seg_next;
      if (memwrite && io_sel) begin
        if (io_addr == ADDR_LED)  led_reg  <= writedata[15:0];
        if (io_addr == ADDR_DISP) disp_reg <= writedata;
      end
    end
  end

  always_comb begin
    readdata = 32'h0;
    if (!io_sel) begin
      readdata = ram[ram_idx];
    end else begin
      case (io_addr)
        ADDR_SW:   readdata = {16'h0, sw_sync_reg};
        ADDR_LED:  readdata = {16'h0, led_reg};
        ADDR_DISP: readdata = disp_reg;
        ADDR_STAT: readdata = {29'h0, digit};
        default:   readdata = 32'h0;
      endcase
    end
  end

  assign led = led_reg;
  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: tb/tb_dmem_io.sv
// Self-checking bench for dmem_io: behavioural memory/I-O model plus directed and random traffic.
module tb_dmem_io;
  localparam int RAM_WORDS = 64;
  localparam int SCAN_BITS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [15:0] switch = 16'h0;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;

  dmem_io #(.RAM_WORDS(RAM_WORDS), .SCAN_BITS(SCAN_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .switch    (switch),
    .led       (led),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [RAM_WORDS];
  bit          m_valid [RAM_WORDS];
  logic [15:0] m_led, m_sw1, m_sw2;
  logic [31:0] m_disp;
  int          m_cnt;
  int          m_shown;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
     12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic int digit_of(input int c);
    return (c >> (SCAN_BITS - 3)) & 7;
  endfunction

  function automatic bit lit(input int d, input logic [31:0] disp);
`ifdef DMEM_IO_BLANK_EN
    return (d == 0) || ((disp >> (4 * d)) != 32'h0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_disp = '0; m_cnt = 0; m_sw1 = '0; m_sw2 = '0;
    m_shown = 0; m_an = 8'hFE; m_seg = 7'h40;
  endtask

  task automatic compare_all();
    int idx;
    check("led", {16'h0, led}, {16'h0, m_led});
    check("an", {24'h0, an}, {24'h0, m_an});
    check("seg", {25'h0, seg}, {25'h0, m_seg});
    if (!dataadr[7]) begin
      idx = int'(dataadr[31:2]) % RAM_WORDS;
      if (m_valid[idx]) check("rd_ram", readdata, m_mem[idx]);
    end else begin
      case ({dataadr[7:2], 2'b00})
        8'h80:   check("rd_sw", readdata, {16'h0, m_sw2});
        8'h84:   check("rd_led", readdata, {16'h0, m_led});
        8'h88:   check("rd_disp", readdata, m_disp);
        8'h8C:   check("rd_stat", readdata, digit_of(m_cnt));
        default: check("rd_unmapped", readdata, 32'h0);
      endcase
    end
  endtask

  task automatic model_edge();
    int d, idx;
    if (reset) return;
    d = digit_of(m_cnt);
    m_shown = d;
    m_an = lit(d, m_disp) ? ~(8'h01 << d) : 8'hFF;
    m_seg = glyph(int'((m_disp >> (4 * d)) & 32'hF));
    if (memwrite) begin
      if (!dataadr[7]) begin
        idx = int'(dataadr[31:2]) % RAM_WORDS;
        m_mem[idx] = writedata;
        m_valid[idx] = 1'b1;
      end else if ({dataadr[7:2], 2'b00} == 8'h84) begin
        m_led = writedata[15:0];
      end else if ({dataadr[7:2], 2'b00} == 8'h88) begin
        m_disp = writedata;
      end
    end
    m_sw2 = m_sw1;
    m_sw1 = switch;
    m_cnt = (m_cnt + 1) % (1 << SCAN_BITS);
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d);
    memwrite = w; dataadr = a; writedata = d;
    cycle();
  endtask

  initial begin
    int hits0, hits7;
    logic [7:0] mask;
    for (int i = 0; i < RAM_WORDS; i++) m_valid[i] = 1'b0;
    model_reset();

    // Reset with a store pending: the store must be lost.
    #2 reset = 1'b1;
    op(1'b1, 32'h84, 32'hFFFF);
    op(1'b1, 32'h84, 32'hFFFF);
    reset = 1'b0;
    op(1'b0, 32'h88, 32'h0);
    check("led_after_reset", {16'h0, led}, 32'h0);
    check("disp_after_reset", readdata, 32'h0);

    // RAM store / load / aliasing
    op(1'b1, 32'h00, 32'h11111111);
    op(1'b1, 32'h04, 32'hDEADBEEF);
    memwrite = 1'b0; dataadr = 32'h04; #1;
    check("ram_load_04", readdata, 32'hDEADBEEF);
    dataadr = 32'h00; #1;
    check("ram_load_00", readdata, 32'h11111111);
    op(1'b1, 32'h104, 32'hCAFEF00D);
    memwrite = 1'b0; dataadr = 32'h04; #1;
    check("ram_alias_104", readdata, 32'hCAFEF00D);

    // LEDs, read-only and unmapped I/O
    op(1'b1, 32'h84, 32'h0000A5A5);
    check("led_write", {16'h0, led}, 32'h0000A5A5);
    memwrite = 1'b0; dataadr = 32'h84; #1;
    check("led_read", readdata, 32'h0000A5A5);
    op(1'b1, 32'h80, 32'hFFFFFFFF);
    op(1'b1, 32'h90, 32'hFFFFFFFF);
    memwrite = 1'b0; dataadr = 32'h90; #1;
    check("unmapped_read", readdata, 32'h0);
    dataadr = 32'h80; #1;
    check("sw_ro", readdata, 32'h0);

    // Switch synchronizer latency
    switch = 16'h1234; #1;
    check("sw_edge0", readdata, 32'h0);
    op(1'b0, 32'h80, 32'h0);
    check("sw_edge1", readdata, 32'h0);
    op(1'b0, 32'h80, 32'h0);
    check("sw_edge2", readdata, 32'h00001234);

    // Display scan
    op(1'b1, 32'h88, 32'h89ABCDEF);
    hits0 = 0; hits7 = 0;
    for (int i = 0; i < 24; i++) begin
      op(1'b0, 32'h8C, 32'h0);
      if (m_shown == 0) begin
        hits0++;
        check("scan_d0_an", {24'h0, an}, 32'hFE);
        check("scan_d0_seg", {25'h0, seg}, 32'h0E);
      end else if (m_shown == 7) begin
        hits7++;
        check("scan_d7_an", {24'h0, an}, 32'h7F);
        check("scan_d7_seg", {25'h0, seg}, 32'h00);
      end
    end
    check("scan_d0_seen", (hits0 > 0) ? 32'h1 : 32'h0, 32'h1);
    check("scan_d7_seen", (hits7 > 0) ? 32'h1 : 32'h0, 32'h1);

    // Reset mid-scan
    op(1'b0, 32'h8C, 32'h0);
    reset = 1'b1; model_reset(); dataadr = 32'h88; #1;
    check("rst_an", {24'h0, an}, 32'hFE);
    check("rst_seg", {25'h0, seg}, 32'h40);
    check("rst_disp", readdata, 32'h0);
    op(1'b0, 32'h88, 32'h0);
    reset = 1'b0; dataadr = 32'h8C; #1;
    check("cnt_restart0", readdata, 32'h0);
    op(1'b0, 32'h8C, 32'h0);
    op(1'b0, 32'h8C, 32'h0);
    check("cnt_restart2", readdata, 32'h1);

    // Blanking of leading zeros
    op(1'b1, 32'h88, 32'h000000A5);
    op(1'b0, 32'h8C, 32'h0);
    mask = 8'h0;
    for (int i = 0; i < 20; i++) begin op(1'b0, 32'h8C, 32'h0); mask |= ~an; end
`ifdef DMEM_IO_BLANK_EN
    check("blank_a5_mask", {24'h0, mask}, 32'h03);
`else
    check("blank_a5_mask", {24'h0, mask}, 32'hFF);
`endif
    op(1'b1, 32'h88, 32'h0);
    op(1'b0, 32'h8C, 32'h0);
    mask = 8'h0;
    for (int i = 0; i < 20; i++) begin op(1'b0, 32'h8C, 32'h0); mask |= ~an; end
`ifdef DMEM_IO_BLANK_EN
    check("blank_zero_mask", {24'h0, mask}, 32'h01);
`else
    check("blank_zero_mask", {24'h0, mask}, 32'hFF);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a;
      case ($urandom % 3)
        0:       a = {$urandom, 2'b00} & 32'hFFFF_FF7C;
        1:       a = ($urandom & 32'hFFFF_FF03) | 32'h80 | (($urandom % 8) << 2);
        default: a = 32'h80 | (($urandom % 4) << 2);
      endcase
      if ($urandom % 8 == 0) switch = 16'($urandom);
      if ($urandom % 60 == 0) begin
        reset = 1'b1; model_reset();
        op(1'($urandom), a, $urandom);
        reset = 1'b0;
      end else begin
        op(1'($urandom), a, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
